// File: rtl/axi_burst_reader.sv
// AXI4 read master: splits a line-read command into 4 KB-safe AR bursts and
// streams the returned lines through an output FIFO that always has room for a burst.
module axi_burst_reader #(
  parameter logic [15:0] ID         = 16'h0,
  parameter int          MAX_BURST  = 16,
  parameter int          FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  cmd_addr,
  input  logic [31:0]  cmd_lines,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  output logic [511:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         done,
  output logic         err,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m
);
  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] MAX_LEN = 32'(MAX_BURST);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FLUSH} state_t;

  state_t        state, state_nxt;
  logic [63:0]   addr;
  logic [31:0]   remaining;
  logic [31:0]   burst_len;
  logic [8:0]    beats;
  logic [31:0]   page_left, len, free;
  logic [PW:0]   count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [511:0]  data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic          push, pop, final_beat, last_of_cmd, beat_err;

  // Burst length is limited by lines left, MAX_BURST and the distance to the next 4 KB page.
  always_comb begin
    page_left = 32'd64 - {26'd0, addr[11:6]};
    len       = remaining;
    if (len > MAX_LEN)   len = MAX_LEN;
    if (len > page_left) len = page_left;
  end

  assign free        = 32'(FIFO_DEPTH) - 32'(count);
  assign push        = rvalid_m && rready_m;
  assign pop         = out_valid && out_ready;
  assign final_beat  = (beats == 9'd1);
  assign last_of_cmd = final_beat && (remaining == burst_len);
  assign beat_err    = (rresp_m != 2'd0) || (rid_m != ID) || (rlast_m != final_beat);

  assign arid_m    = ID;
  assign araddr_m  = addr;
  assign arsize_m  = 3'd6;
  assign out_valid = (count != '0);
  assign out_data  = data_mem[rd_ptr];
  assign out_last  = out_valid && last_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // arvalid_m stays stable while waiting: free space can only grow outside DATA.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    arvalid_m = 1'b0;
    arlen_m   = 8'd0;
    rready_m  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_lines == 32'd0) ? FLUSH : ADDR;
      end
      ADDR: begin
        arlen_m = len[7:0] - 8'd1;
        if (free >= len) begin
          arvalid_m = 1'b1;
          if (arready_m) state_nxt = DATA;
        end
      end
      DATA: begin
        rready_m = 1'b1;
        if (rvalid_m && final_beat) state_nxt = last_of_cmd ? FLUSH : ADDR;
      end
      FLUSH: begin
        if (count == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= 64'd0;
      remaining <= 32'd0;
      burst_len <= 32'd0;
      beats     <= 9'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr      <= cmd_addr & ~64'h3F;
          remaining <= cmd_lines;
          err       <= 1'b0;
        end
        ADDR: if (arvalid_m && arready_m) begin
          beats     <= len[8:0];
          burst_len <= len;
        end
        DATA: if (push) begin
          beats <= beats - 9'd1;
          if (beat_err) err <= 1'b1;
          if (final_beat) begin
            addr      <= addr + {26'd0, burst_len, 6'd0};
            remaining <= remaining - burst_len;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_mem <= '0;
    end else begin
      if (push) begin
        wr_ptr           <= wr_ptr + PTR_ONE;
        last_mem[wr_ptr] <= last_of_cmd;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_mem[wr_ptr] <= rdata_m;
  end
endmodule

// File: tb/tb_axi_burst_reader.sv
// Randomized bench for axi_burst_reader: AXI memory emulator, random sink and a
// line/burst reference model built from address arithmetic.
module tb_axi_burst_reader;
  localparam logic [15:0] ID         = 16'h0;
  localparam int          MAX_BURST  = 16;
  localparam int          FIFO_DEPTH = 32;
  localparam logic [63:0] WORDS      = 64'd4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  cmd_addr;
  logic [31:0]  cmd_lines;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [511:0] out_data;
  logic         out_last, out_valid, out_ready;
  logic         done, err;
  logic [15:0]  arid_m;
  logic [63:0]  araddr_m;
  logic [7:0]   arlen_m;
  logic [2:0]   arsize_m;
  logic         arvalid_m, arready_m;
  logic [15:0]  rid_m;
  logic [511:0] rdata_m;
  logic [1:0]   rresp_m;
  logic         rlast_m, rvalid_m, rready_m;

  axi_burst_reader #(.ID(ID), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_lines(cmd_lines), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [63:0] idx; logic last; } line_t;

  ar_t   exp_ar[$];
  line_t exp_lines[$];
  line_t r_q[$];

  int total = 0;
  int bad   = 0;
  int ar_count;
  bit exp_done, done_seen, hold_out, after_accept, ar_pend, exp_err, exp_ar_first;

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] line_data(input logic [63:0] idx);
    logic [511:0] d;
    for (int k = 0; k < 16; k++)
      d[k*32 +: 32] = ((idx[31:0] + 32'(k)) * 32'h9E3779B1) ^ 32'hA5A5A5A5;
    return d;
  endfunction

  // Expected AR sequence and line stream straight from the burst-splitting rules.
  task automatic buildModel(input logic [63:0] addr, input logic [31:0] lines);
    logic [63:0] a, page, l, idx;
    logic [31:0] rem;
    ar_t  e;
    line_t ln;
    a   = addr & ~64'h3F;
    rem = lines;
    while (rem > 0) begin
      page = 64'd64 - ((a >> 6) & 64'd63);
      l    = 64'(rem);
      if (l > 64'(MAX_BURST)) l = 64'(MAX_BURST);
      if (l > page) l = page;
      e.addr = a;
      e.len  = 8'(l - 64'd1);
      exp_ar.push_back(e);
      a   = a + l * 64'd64;
      rem = rem - 32'(l);
    end
    for (logic [63:0] i = 0; i < 64'(lines); i++) begin
      idx     = (addr >> 6) + i;
      ln.idx  = idx;
      ln.last = (i == 64'(lines) - 64'd1);
      exp_lines.push_back(ln);
      if (idx >= WORDS) exp_err = 1'b1;
    end
  endtask

  // One clock of emulator, sink and checks, evaluated at the falling edge.
  task automatic tick(input bit issue);
    line_t h, n;
    ar_t   e;
    @(negedge clk);
    checkOutput("done", 512'(done), 512'(exp_done));
    if (done) done_seen = 1'b1;
    exp_done = 1'b0;
    if (after_accept) begin
      checkOutput("cmd_ready_busy", 512'(cmd_ready), 512'(0));
      checkOutput("err_cleared", 512'(err), 512'(0));
      checkOutput("ar_first", 512'(arvalid_m), 512'(exp_ar_first));
      after_accept = 1'b0;
    end
    cmd_valid = issue;
    if (issue) begin
      checkOutput("cmd_ready", 512'(cmd_ready), 512'(1));
      after_accept = 1'b1;
      if (cmd_lines == 32'd0) exp_done = 1'b1;
    end

    if (r_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      h        = r_q[0];
      rvalid_m = 1'b1;
      rdata_m  = line_data(h.idx);
      rresp_m  = (h.idx >= WORDS) ? 2'h2 : 2'h0;
      rlast_m  = h.last;
      rid_m    = ID;
      if (rready_m) void'(r_q.pop_front());
    end else begin
      rvalid_m = 1'b0;
      rlast_m  = 1'b0;
    end

    if (ar_pend) checkOutput("ar_hold", 512'(arvalid_m), 512'(1));
    arready_m = ($urandom_range(0, 2) != 0);
    ar_pend   = arvalid_m && !arready_m;
    if (arvalid_m && arready_m) begin
      ar_count++;
      if (exp_ar.size() == 0) checkOutput("extra_ar", 512'(arvalid_m), 512'(0));
      else begin
        e = exp_ar.pop_front();
        checkOutput("araddr", 512'(araddr_m), 512'(e.addr));
        checkOutput("arlen", 512'(arlen_m), 512'(e.len));
        checkOutput("arsize", 512'(arsize_m), 512'(3'd6));
        checkOutput("arid", 512'(arid_m), 512'(ID));
      end
      for (int i = 0; i <= int'(arlen_m); i++) begin
        n.idx  = (araddr_m >> 6) + 64'(i);
        n.last = (i == int'(arlen_m));
        r_q.push_back(n);
      end
    end

    out_ready = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (out_valid && out_ready) begin
      if (exp_lines.size() == 0) checkOutput("extra_line", 512'(out_valid), 512'(0));
      else begin
        h = exp_lines.pop_front();
        checkOutput("out_data", out_data, line_data(h.idx));
        checkOutput("out_last", 512'(out_last), 512'(h.last));
        if (h.last) exp_done = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [63:0] addr, input logic [31:0] lines, input int hold);
    int n;
    cmd_addr     = addr;
    cmd_lines    = lines;
    exp_err      = 1'b0;
    exp_ar_first = (lines != 32'd0);
    ar_count     = 0;
    done_seen    = 1'b0;
    buildModel(addr, lines);
    hold_out = (hold > 0);
    tick(1'b1);
    if (hold > 0) begin
      repeat (hold) tick(1'b0);
      checkOutput("stall_ar_count", 512'(ar_count), 512'(FIFO_DEPTH / MAX_BURST));
      checkOutput("stall_arvalid", 512'(arvalid_m), 512'(0));
      hold_out = 1'b0;
    end
    n = 0;
    while (!done_seen && n < 5000) begin
      tick(1'b0);
      n++;
    end
    checkOutput("timeout", 512'(done_seen), 512'(1));
    checkOutput("ar_left", 512'(exp_ar.size()), 512'(0));
    checkOutput("lines_left", 512'(exp_lines.size()), 512'(0));
    checkOutput("err_final", 512'(err), 512'(exp_err));
    exp_ar.delete();
    exp_lines.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    arready_m = 1'b0;
    rvalid_m  = 1'b0;
    rlast_m   = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("rst_arvalid", 512'(arvalid_m), 512'(0));
    checkOutput("rst_rready", 512'(rready_m), 512'(0));
    checkOutput("rst_out_valid", 512'(out_valid), 512'(0));
    checkOutput("rst_out_last", 512'(out_last), 512'(0));
    checkOutput("rst_done", 512'(done), 512'(0));
    checkOutput("rst_err", 512'(err), 512'(0));
    checkOutput("rst_araddr", 512'(araddr_m), 512'(0));
    checkOutput("rst_arlen", 512'(arlen_m), 512'(0));
    checkOutput("rst_arid", 512'(arid_m), 512'(0));
    checkOutput("rst_arsize", 512'(arsize_m), 512'(3'd6));
    checkOutput("rst_cmd_ready", 512'(cmd_ready), 512'(1));
    r_q.delete();
    exp_ar.delete();
    exp_lines.delete();
    exp_done     = 1'b0;
    ar_pend      = 1'b0;
    after_accept = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_addr  = 64'd0;
    cmd_lines = 32'd0;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    arready_m = 1'b0;
    rid_m     = 16'd0;
    rdata_m   = '0;
    rresp_m   = 2'd0;
    rlast_m   = 1'b0;
    rvalid_m  = 1'b0;
    hold_out  = 1'b0;
    exp_done  = 1'b0;
    doReset();

    applyStimulus(64'h0, 32'd1, 0);
    applyStimulus(64'h0, 32'd40, 0);
    applyStimulus(64'hF80, 32'd4, 0);
    applyStimulus(64'h0, 32'd64, 200);
    applyStimulus((WORDS - 64'd3) * 64'd64, 32'd8, 0);
    applyStimulus(64'h0, 32'd0, 0);
    applyStimulus(64'h1234, 32'd3, 0);

    cmd_addr  = 64'h0;
    cmd_lines = 32'd40;
    ar_count  = 0;
    exp_ar_first = 1'b1;
    buildModel(cmd_addr, cmd_lines);
    tick(1'b1);
    repeat (15) tick(1'b0);
    doReset();

    applyStimulus(64'h2040, 32'd20, 0);
    for (int k = 0; k < 8; k++)
      applyStimulus((64'($urandom_range(0, 4000)) << 6) | 64'($urandom_range(0, 63)),
                    32'($urandom_range(1, 70)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
